// File: rtl/button_conditioner.sv
// button_conditioner
//
// Multi-channel pushbutton front end. Each raw pin goes through a 2-flop
// synchronizer and then a four-state debounce FSM. The outputs per channel are
// a clean pressed level plus single-cycle press, release and long-press
// strobes. All outputs are registered.
//
// Parameters:
//   N_CH         number of independent channels (>=1)
//   DEBOUNCE_CYC synchronized cycles a new level must persist (>=1)
//   LONG_CYC     cycles after the press strobe until the long strobe (>=1)
//   ACTIVE_LOW   1: pin reads 0 when pressed (pull-up), 0: active-high pin
//
// Ports:
//   CLK          board clock, rising edge
//   RST          asynchronous active-high reset
//   btn_raw      raw asynchronous button pins
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle strobe on accepted press
//   btn_release  one-cycle strobe on accepted release
//   btn_long     one-cycle strobe when a hold reaches LONG_CYC
module button_conditioner #(
  parameter int N_CH         = 2,
  parameter int DEBOUNCE_CYC = 160000,
  parameter int LONG_CYC     = 16000000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          sync0_reg;
    logic          sync1_reg;
    logic          s;
    state_t        state_reg;
    logic [DW-1:0] dcnt_reg;
    logic [LW-1:0] lcnt_reg;
    logic          level_reg;
    logic          press_reg;
    logic          release_reg;
    logic          long_reg;
    logic          lcnt_full;
    logic          lcnt_last;

    // Normalized synchronized level: 1 means pressed for either pin polarity.
    assign s = sync1_reg ^ ACTIVE_LOW;

    // The long counter saturates; the strobe fires only on the step into LONG_CYC.
    assign lcnt_full = (lcnt_reg == LW'(LONG_CYC));
    assign lcnt_last = (lcnt_reg == LW'(LONG_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        // Synchronizer holds the idle pin level so no press follows reset.
        sync0_reg   <= ACTIVE_LOW;
        sync1_reg   <= ACTIVE_LOW;
        state_reg   <= RELEASED;
        dcnt_reg    <= '0;
        lcnt_reg    <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;
      end else begin
        sync0_reg   <= btn_raw[gi];
        sync1_reg   <= sync0_reg;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;

        case (state_reg)
          RELEASED: begin
            if (s) begin
              state_reg <= PRESS_PEND;
              dcnt_reg  <= DW'(1);
            end
          end

          PRESS_PEND: begin
            if (!s) begin
              // Bounce: drop back without any strobe.
              state_reg <= RELEASED;
              dcnt_reg  <= '0;
            end else if (dcnt_reg == DW'(DEBOUNCE_CYC)) begin
              state_reg <= PRESSED;
              dcnt_reg  <= '0;
              level_reg <= 1'b1;
              press_reg <= 1'b1;
              lcnt_reg  <= '0;
            end else begin
              dcnt_reg <= dcnt_reg + DW'(1);
            end
          end

          PRESSED: begin
            if (!lcnt_full) begin
              lcnt_reg <= lcnt_reg + LW'(1);
              long_reg <= lcnt_last;
            end
            if (!s) begin
              state_reg <= RELEASE_PEND;
              dcnt_reg  <= DW'(1);
            end
          end

          RELEASE_PEND: begin
            // The hold is still in progress while a release is pending, so
            // the long counter keeps running here too.
            if (!lcnt_full) begin
              lcnt_reg <= lcnt_reg + LW'(1);
              long_reg <= lcnt_last;
            end
            if (s) begin
              state_reg <= PRESSED;
              dcnt_reg  <= '0;
            end else if (dcnt_reg == DW'(DEBOUNCE_CYC)) begin
              state_reg   <= RELEASED;
              dcnt_reg    <= '0;
              level_reg   <= 1'b0;
              release_reg <= 1'b1;
            end else begin
              dcnt_reg <= dcnt_reg + DW'(1);
            end
          end

          default: begin
            state_reg <= RELEASED;
            dcnt_reg  <= '0;
          end
        endcase
      end
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
    assign btn_long[gi]    = long_reg;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with N_CH=2, DEBOUNCE_CYC=4, LONG_CYC=20,
// ACTIVE_LOW=1. Directed scenarios check absolute strobe timing; a randomized
// scenario compares every cycle with a run-length reference model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       CLK;
  logic       RST;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int checks;
  int errors;

  // Reference model state.
  logic [1:0] exp_level;
  logic [1:0] exp_press;
  logic [1:0] exp_release;
  logic [1:0] exp_long;
  int         m_run[2];    // consecutive samples disagreeing with the level
  int         m_since[2];  // cycles since the press strobe (saturates at LONG)
  logic [1:0] raw_hist[$]; // raw pin values still travelling to the FSM

  button_conditioner #(
    .N_CH        (2),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    exp_level   = 2'b00;
    exp_press   = 2'b00;
    exp_release = 2'b00;
    exp_long    = 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_run[c]   = 0;
      m_since[c] = LONG;
    end
    raw_hist.delete();
    raw_hist.push_back(2'b11);
    raw_hist.push_back(2'b11);
  endtask

  // Drive raw, take one rising edge, advance the model, settle 1 time unit.
  // A pin value reaches the decision logic two edges after it was sampled; a
  // new level is accepted once DEB+1 consecutive samples disagree with it.
  task automatic tick(input logic [1:0] raw);
    logic [1:0] s;
    btn_raw = raw;
    @(posedge CLK);
    s = ~raw_hist.pop_front();
    raw_hist.push_back(raw);
    exp_press   = 2'b00;
    exp_release = 2'b00;
    exp_long    = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (exp_level[c] && m_since[c] < LONG) begin
        m_since[c]++;
        if (m_since[c] == LONG) exp_long[c] = 1'b1;
      end
      if (s[c] != exp_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB + 1) begin
          m_run[c]     = 0;
          exp_level[c] = s[c];
          if (s[c]) begin
            exp_press[c] = 1'b1;
            m_since[c]   = 0;
          end else begin
            exp_release[c] = 1'b1;
          end
        end
      end else begin
        m_run[c] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 2'b10;
    RST     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 00000000",
                 {btn_level, btn_press, btn_release, btn_long});
      end
      @(posedge CLK);
    end
    #1;
    RST = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      tick(2'b10);
      checks++;
      if (btn_press !== ((k == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL reset_held_press k=%0d: got %b want %b", k, btn_press,
                 (k == 6) ? 2'b01 : 2'b00);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(2'b11);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        errors++;
        $display("FAIL reset_idle k=%0d: got %b want %b", k,
                 {btn_level, btn_press, btn_release, btn_long},
                 {exp_level, exp_press, exp_release, exp_long});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] want;
    for (int k = 0; k < 30; k++) begin
      tick(2'b10);
      want = {1'b0, (k >= 6) ? 1'b1 : 1'b0,
              1'b0, (k == 6) ? 1'b1 : 1'b0,
              2'b00,
              1'b0, (k == 26) ? 1'b1 : 1'b0};
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== want) begin
        errors++;
        $display("FAIL clean_press k=%0d: got %b want %b", k,
                 {btn_level, btn_press, btn_release, btn_long}, want);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(2'b11);
      checks++;
      if (btn_release !== ((k == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_release k=%0d: got %b want %b", k, btn_release,
                 (k == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pat[$];
    pat = {2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
    for (int k = 0; k < 10; k++) pat.push_back(2'b11);
    foreach (pat[k]) begin
      tick(pat[k]);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
        errors++;
        $display("FAIL bounce k=%0d: got %b want 00000000", k,
                 {btn_level, btn_press, btn_release, btn_long});
      end
    end
  endtask

  task automatic test_release_bounce();
    for (int k = 0; k < 8; k++) tick(2'b10);
    checks++;
    if (btn_level !== 2'b01) begin
      errors++;
      $display("FAIL rel_bounce_setup: got level %b want 01", btn_level);
    end
    tick(2'b11);
    tick(2'b11);
    tick(2'b10);
    checks++;
    if (btn_level !== 2'b01 || btn_release !== 2'b00) begin
      errors++;
      $display("FAIL rel_bounce_early: got level %b release %b want 01 00",
               btn_level, btn_release);
    end
    // k=0 is the edge sampling the final, steady rise.
    for (int k = 0; k < 10; k++) begin
      tick(2'b11);
      checks++;
      if ({btn_level, btn_release} !==
          {(k >= 6) ? 2'b00 : 2'b01, (k == 6) ? 2'b01 : 2'b00}) begin
        errors++;
        $display("FAIL rel_bounce k=%0d: got level %b release %b", k,
                 btn_level, btn_release);
      end
    end
  endtask

  task automatic test_both_short();
    for (int k = 0; k < 24; k++) begin
      tick((k < 10) ? 2'b00 : 2'b11);
      checks++;
      if ({btn_press, btn_release, btn_long} !==
          {(k == 6) ? 2'b11 : 2'b00, (k == 16) ? 2'b11 : 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL both_short k=%0d: got press %b release %b long %b", k,
                 btn_press, btn_release, btn_long);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      tick(2'b10);
      checks++;
      if (btn_press !== 2'b00) begin
        errors++;
        $display("FAIL mid_pre k=%0d: got press %b want 00", k, btn_press);
      end
    end
    #2;
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset k=%0d: got %b want 00000000", k,
                 {btn_level, btn_press, btn_release, btn_long});
      end
      @(posedge CLK);
    end
    #1;
    RST = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      tick(2'b10);
      checks++;
      if (btn_press !== ((k == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL mid_after k=%0d: got press %b want %b", k, btn_press,
                 (k == 6) ? 2'b01 : 2'b00);
      end
    end
    for (int k = 0; k < 12; k++) tick(2'b11);
    checks++;
    if (btn_level !== 2'b00) begin
      errors++;
      $display("FAIL mid_idle: got level %b want 00", btn_level);
    end
  endtask

  task automatic test_random();
    logic [1:0] cur;
    int         hold[2];
    cur     = 2'b11;
    hold[0] = 0;
    hold[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = ~cur[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 35)
                                                : $urandom_range(1, 7);
        end
        hold[c]--;
      end
      if ($urandom_range(0, 199) == 0) begin
        btn_raw = cur;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
          errors++;
          $display("FAIL rand_reset n=%0d: got %b want 00000000", n,
                   {btn_level, btn_press, btn_release, btn_long});
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
      end
      tick(cur);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        errors++;
        $display("FAIL random n=%0d raw=%b: got %b want %b", n, cur,
                 {btn_level, btn_press, btn_release, btn_long},
                 {exp_level, exp_press, exp_release, exp_long});
      end
      checks++;
      if ((btn_press & btn_release) !== 2'b00) begin
        errors++;
        $display("FAIL strobe_excl n=%0d: got press %b release %b", n,
                 btn_press, btn_release);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    RST     = 1'b1;
    btn_raw = 2'b10;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_both_short();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
